// File: rtl/layer_sequencer.sv
// Control FSM for one fully connected layer: clear, fetch/MAC per input element, bias, activation, handoff.
// All req/valid/status outputs are flops; each handshake takes at least one cycle, stalls hold the request.
module layer_sequencer #(
  parameter int N_IN = 2,
  parameter int AW   = 1,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          in_req,
  output logic [AW-1:0] in_addr,
  input  logic          in_ack,
  output logic          mac_clr,
  output logic          mac_req,
  input  logic          mac_ack,
  output logic          add_req,
  input  logic          add_ack,
  output logic          act_req,
  input  logic          act_ack,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_MAC, S_BIAS, S_ACT, S_WRITE
  } state_t;

  localparam logic [AW-1:0] K_LAST = AW'(N_IN - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_req_q, in_req_d;
  logic          mac_clr_q, mac_clr_d;
  logic          mac_req_q, mac_req_d;
  logic          add_req_q, add_req_d;
  logic          act_req_q, act_req_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic          spurious;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_req_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_req_q   <= 1'b0;
      add_req_q   <= 1'b0;
      act_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cycles_q    <= cycles_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_req_q    <= in_req_d;
      mac_clr_q   <= mac_clr_d;
      mac_req_q   <= mac_req_d;
      add_req_q   <= add_req_d;
      act_req_q   <= act_req_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          k_d     = '0;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: if (in_ack) state_d = S_MAC;
      S_MAC: begin
        if (mac_ack) begin
          if (k_q == K_LAST) begin
            state_d = S_BIAS;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_BIAS:  if (add_ack)   state_d = S_ACT;
      S_ACT:   if (act_ack)   state_d = S_WRITE;
      S_WRITE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are decoded from the next state so they rise on state entry and drop right after the ack.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_WRITE) && out_ready;
    mac_clr_d   = (state_d == S_CLEAR);
    in_req_d    = (state_d == S_FETCH);
    mac_req_d   = (state_d == S_MAC);
    add_req_d   = (state_d == S_BIAS);
    act_req_d   = (state_d == S_ACT);
    out_valid_d = (state_d == S_WRITE);

    spurious = (in_ack    && !in_req_q)  ||
               (mac_ack   && !mac_req_q) ||
               (add_ack   && !add_req_q) ||
               (act_ack   && !act_req_q) ||
               (out_ready && !out_valid_q);
    err_d = err_q || spurious;

    cycles_d = cycles_q;
    if (state_q == S_IDLE && start) begin
      cycles_d = '0;
    end else if (busy_q && (cycles_q != '1)) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_req    = in_req_q;
  assign in_addr   = k_q;
  assign mac_clr   = mac_clr_q;
  assign mac_req   = mac_req_q;
  assign add_req   = add_req_q;
  assign act_req   = act_req_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: randomized ack delays, expected handshake sequence queued per pass, negedge monitor.
`timescale 1ns/1ps
module tb_layer_sequencer;

  localparam int N_IN = 2;
  localparam int AW   = 1;
  localparam int CW   = 16;
  localparam int NHS  = 2 * N_IN + 3;

  localparam int EV_CLR  = 0;
  localparam int EV_IN   = 1;
  localparam int EV_MAC  = 2;
  localparam int EV_ADD  = 3;
  localparam int EV_ACT  = 4;
  localparam int EV_OUT  = 5;
  localparam int EV_DONE = 6;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          in_ack, mac_ack, add_ack, act_ack, out_ready;
  logic          busy, done, in_req, mac_clr, mac_req, add_req, act_req, out_valid, err;
  logic [AW-1:0] in_addr;
  logic [CW-1:0] cycles;

  typedef struct {
    int kind;
    int data;
    int eflag;
  } ev_t;

  ev_t exp_q[$];
  int  dq[5][$];
  int  dly[NHS];
  int  n_cmp   = 0;
  int  n_bad   = 0;
  int  exp_err = 0;
  int  exp_cyc = 0;
  int  spur_ch = 0;
  bit  spur_arm = 1'b0;

  layer_sequencer #(.N_IN(N_IN), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_req(in_req), .in_addr(in_addr), .in_ack(in_ack),
    .mac_clr(mac_clr), .mac_req(mac_req), .mac_ack(mac_ack),
    .add_req(add_req), .add_ack(add_ack), .act_req(act_req), .act_ack(act_ack),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ev(input int kind, input int data, input int ef);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%0d err=%0d, required none", kind, data, ef);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.eflag != ef) begin
        n_bad++;
        $display("FAIL event_seq: got kind=%0d data=%0d err=%0d, required kind=%0d data=%0d err=%0d",
                 kind, data, ef, e.kind, e.data, e.eflag);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    logic [CW+AW+8:0] v;
    v = {busy, done, in_req, in_addr, mac_clr, mac_req, add_req, act_req, out_valid, err, cycles};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, required all zero", nm, v);
    end
  endtask

  // Reference model: a pass is CLEAR, then (fetch k, mac k) per element, then bias/act/out handshakes.
  // Each handshake occupies (delay + 1) busy cycles; CLEAR occupies one.
  task automatic plan_pass(input int sp);
    int cyc;
    cyc = 1;
    exp_q.push_back('{EV_CLR, 0, 0});
    for (int k = 0; k < N_IN; k++) begin
      dq[0].push_back(dly[2*k]);
      exp_q.push_back('{EV_IN, k, 0});
      dq[1].push_back(dly[2*k+1]);
      exp_q.push_back('{EV_MAC, k, 0});
    end
    dq[2].push_back(dly[2*N_IN]);
    exp_q.push_back('{EV_ADD, 0, 0});
    dq[3].push_back(dly[2*N_IN+1]);
    exp_q.push_back('{EV_ACT, 0, 0});
    dq[4].push_back(dly[2*N_IN+2]);
    exp_q.push_back('{EV_OUT, 0, 0});
    for (int i = 0; i < NHS; i++) cyc += dly[i] + 1;
    if (cyc > 65535) cyc = 65535;
    if (sp >= 0) begin
      exp_err  = 1;
      spur_ch  = sp;
      spur_arm = 1'b1;
    end
    exp_q.push_back('{EV_DONE, cyc, exp_err});
    exp_cyc = cyc;
  endtask

  task automatic set_dly(input int f, input int m, input int a, input int c, input int o);
    for (int k = 0; k < N_IN; k++) begin
      dly[2*k]   = f;
      dly[2*k+1] = m;
    end
    dly[2*N_IN]   = a;
    dly[2*N_IN+1] = c;
    dly[2*N_IN+2] = o;
  endtask

  task automatic do_reset(input string nm);
    rst   = 1'b1;
    start = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 5; i++) dq[i].delete();
    spur_arm = 1'b0;
    exp_err  = 0;
    check_zero(nm);
    rst = 1'b0;
  endtask

  // Starts in an IDLE cycle and returns in the done cycle, so a following call is a back-to-back start.
  task automatic run_pass(input int sp, input bit mid_start);
    int lat;
    bit seen;
    plan_pass(sp);
    start = 1'b1;
    tick();
    lat  = 0;
    seen = 1'b0;
    while (lat <= 400) begin
      start = mid_start && (lat == 2);
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles, required latency %0d", lat, exp_cyc);
      do_reset("timeout_recovery");
    end else if (lat != exp_cyc) begin
      n_bad++;
      $display("FAIL latency: done after %0d cycles, required %0d", lat, exp_cyc);
    end
  endtask

  // Responder: acks each request after its planned delay; optionally injects one stray ack.
  initial begin
    int        cnt[5];
    int        hd;
    logic [4:0] rq, a;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    {out_ready, act_ack, add_ack, mac_ack, in_ack} = '0;
    forever begin
      @(posedge clk);
      #1;
      rq = {out_valid, act_req, add_req, mac_req, in_req};
      a  = '0;
      for (int i = 0; i < 5; i++) begin
        if (rq[i] && !rst) begin
          hd = (dq[i].size() != 0) ? dq[i][0] : 0;
          if (cnt[i] >= hd) begin
            a[i]   = 1'b1;
            cnt[i] = 0;
            if (dq[i].size() != 0) void'(dq[i].pop_front());
          end else begin
            cnt[i]++;
          end
        end else begin
          cnt[i] = 0;
        end
      end
      if (spur_arm && !rst && ((spur_ch == 0) ? mac_req : in_req)) begin
        a        = a | (5'b1 << spur_ch);
        spur_arm = 1'b0;
      end
      {out_ready, act_ack, add_ack, mac_ack, in_ack} = a;
    end
  end

  // Monitor: every completed handshake and every done pulse is matched against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mac_clr)               check_ev(EV_CLR, 0, 0);
        if (in_req && in_ack)      check_ev(EV_IN, int'(in_addr), 0);
        if (mac_req && mac_ack)    check_ev(EV_MAC, int'(in_addr), 0);
        if (add_req && add_ack)    check_ev(EV_ADD, 0, 0);
        if (act_req && act_ack)    check_ev(EV_ACT, 0, 0);
        if (out_valid && out_ready) check_ev(EV_OUT, 0, 0);
        if (done) begin
          check_ev(EV_DONE, int'(cycles), int'(err));
          n_cmp++;
          if (busy) begin
            n_bad++;
            $display("FAIL busy_at_done: busy=%0b, required 0", busy);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sp;
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check_zero("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_zero("idle_no_start");
    end

    set_dly(0, 0, 0, 0, 0);
    run_pass(-1, 1'b0);
    repeat (2) tick();

    set_dly(3, 0, 0, 0, 0);
    run_pass(-1, 1'b0);
    repeat (2) tick();

    set_dly(0, 0, 0, 0, 5);
    run_pass(-1, 1'b0);
    repeat (3) tick();

    set_dly(2, 0, 0, 0, 0);
    run_pass(2, 1'b0);
    tick();
    set_dly(0, 1, 0, 1, 0);
    run_pass(-1, 1'b1);
    repeat (2) tick();

    set_dly(0, 0, 0, 0, 0);
    dly[3] = 3;
    plan_pass(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mac_req && in_addr == 1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_mac_k1: mac_req=%0b in_addr=%0d, required mac_req=1 in_addr=1", mac_req, in_addr);
    end
    do_reset("reset_mid_pass");
    repeat (5) tick();
    set_dly(1, 0, 1, 0, 2);
    run_pass(-1, 1'b1);
    tick();

    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < NHS; i++) dly[i] = int'($urandom_range(0, 3));
      sp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_pass(sp, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 3))) tick();
    end

    repeat (5) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected: %0d events still pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Control FSM for one fully connected layer datapath (MAC array, bias adder, activation stage) in the fixed-point XOR network.
- Steps through the input vector one element at a time: fetch x[k], run one MAC step, then bias add, activation, and result handoff.
- Reports busy/done/error and a busy-cycle count to the network-level controller.
- Multiple instances are chained by the network controller, one per layer.

Parameters:
- N_IN, 2, number of input elements (MAC steps per inference); legal range 1..2**AW.
- AW, 1, width of in_addr.
- CW, 16, width of the cycle counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one layer pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer result is accepted.
- in_req  out  1  request input element in_addr from the previous layer/input buffer.
- in_addr  out  AW  index k of the requested input element.
- in_ack  in  1  input element valid on the data path this cycle.
- mac_clr  out  1  one-cycle pulse; clears MAC accumulators.
- mac_req  out  1  perform one multiply-accumulate with the current input.
- mac_ack  in  1  MAC step complete.
- add_req  out  1  add bias to accumulators.
- add_ack  in  1  bias add complete.
- act_req  out  1  latch activation outputs.
- act_ack  in  1  activation outputs valid.
- out_valid  out  1  layer result available to the next layer.
- out_ready  in  1  next layer accepts the result.
- err  out  1  sticky protocol-error flag.
- cycles  out  CW  busy cycles of the last or current pass; saturating.

Behaviour:

Reset:
- rst is synchronous and active-high and has priority over everything.
- On reset: state=IDLE; all outputs 0, including in_addr, cycles and err.
- Reset mid-pass aborts immediately. No done pulse is produced.

States: IDLE, CLEAR, FETCH, MAC, BIAS, ACT, WRITE.
- IDLE: when start=1, go to CLEAR. On that transition set k=0 and cycles=0.
- CLEAR: drive mac_clr=1 for exactly one cycle, then go to FETCH.
- FETCH: in_req=1, in_addr=k. When in_ack=1, go to MAC.
- MAC: mac_req=1. When mac_ack=1:
  - if k==N_IN-1, go to BIAS;
  - otherwise k<=k+1 and go to FETCH.
- BIAS: add_req=1. When add_ack=1, go to ACT.
- ACT: act_req=1. When act_ack=1, go to WRITE.
- WRITE: out_valid=1. When out_ready=1, pulse done=1 in the following cycle and return to IDLE.

Handshake rules:
- All req/valid outputs are registered.
- A req/valid output rises on the cycle the state is entered.
- It is held until the cycle in which its ack/ready is sampled high.
- It is low in the next cycle.
- An ack may arrive in the same cycle its req is first seen high, so the minimum is 1 cycle per handshake.
- A request is never dropped before its ack.

Latency:
- With every ack returned immediately, a pass takes 1 (CLEAR) + 2*N_IN + 3 cycles from start sampled to the done pulse.
- For N_IN=2 that is 8 cycles.
- done is asserted in the cycle after the out_ready handshake. busy is 0 in that same cycle.

Boundary conditions:
- start while busy is ignored. It is not queued.
- start in the same cycle as done is accepted, because the FSM is already back in IDLE.
- An ack/ready that arrives while its own req/valid is low sets err=1. The FSM ignores it.
- err is cleared only by rst.
- Simultaneous acks for different stages: only the ack matching the current state is used. The others set err.
- k wraps only through the reset to 0 on start. in_addr never exceeds N_IN-1.
- cycles increments in every cycle with busy=1 and saturates at 2**CW-1. It holds its value in IDLE.
- N_IN=1: the FSM goes directly from MAC to BIAS after the first mac_ack.

Test Plan:
1. Reset then idle, no start -> all outputs 0 for 10 cycles; err=0; cycles=0.
2. N_IN=2, all acks tied to their reqs, start pulse at cycle 0 -> sequence:
   - mac_clr at cycle 1;
   - in_addr=0, then MAC;
   - in_addr=1, then MAC;
   - add_req, act_req, out_valid;
   - done at cycle 8; cycles=8.
3. in_ack delayed 3 cycles for each element -> in_req held constant with in_addr stable while waiting; done at cycle 14; cycles=14.
4. out_ready held low for 5 cycles in WRITE -> out_valid stays high for 6 cycles; exactly one done pulse.
5. Spurious add_ack during FETCH -> err=1, state unaffected. Pass still completes, and err stays 1 until rst.
6. rst asserted during MAC of k=1, then start again -> all outputs 0 the cycle after rst; no done pulse; the new pass restarts at in_addr=0 with mac_clr; start while busy is ignored.
